// File: rtl/i2c_host_arbiter_pkg.sv
// i2c_arb_pkg: FSM state and response status encodings shared by the I2C host arbiter
package i2c_arb_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP, COMPLETE} state_t;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NACK    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
endpackage

// File: rtl/i2c_host_arbiter_if.sv
// i2c_host_arbiter_if: command/status link between the arbiter and the single I2C_Host
interface i2c_host_arbiter_if;
  logic       host_send;
  logic [6:0] host_address;
  logic [7:0] host_data_in;
  logic       host_read_only;
  logic       host_busy;
  logic       host_ack_error;
  logic [7:0] host_data_send;
  modport master (
    output host_send, host_address, host_data_in, host_read_only,
    input  host_busy, host_ack_error, host_data_send
  );
  modport slave (
    input  host_send, host_address, host_data_in, host_read_only,
    output host_busy, host_ack_error, host_data_send
  );
endinterface

// File: rtl/i2c_host_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr (wrapping)
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  // walk offsets from farthest to nearest so the closest request to ptr wins
  always_comb begin
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) gnt_idx = IW'((int'(ptr) + k) % N);
  end
  assign any    = |req;
  assign gnt_oh = any ? N'(1) << gnt_idx : '0;
endmodule

// File: rtl/i2c_host_arbiter.sv
// i2c_host_arbiter: round-robin sharing of one I2C_Host among NUM_REQ single-byte requesters
module i2c_host_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_RETRY    = 2,
  parameter int RETRY_GAP    = 64,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_rd,
  output logic [NUM_REQ-1:0]     done,
  output logic [7:0]             rsp_data,
  output logic [1:0]             rsp_status,
  output logic                   arb_idle,
  i2c_host_arbiter_if.master     bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int GW = $clog2(RETRY_GAP + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] TO_LOAD  = TW'(BUSY_TIMEOUT);
  localparam logic [GW-1:0] GAP_LOAD = GW'(RETRY_GAP);
  localparam logic [RW-1:0] MAX_R    = RW'(MAX_RETRY);
  state_t               state;
  logic [IW-1:0]        rr_ptr, gnt, pick_idx;
  logic [NUM_REQ-1:0]   gnt_oh, pick_oh;
  logic                 pick_any;
  logic [TW-1:0]        to_cnt;
  logic [GW-1:0]        gap_cnt;
  logic [RW-1:0]        retry_cnt;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req(req), .ptr(rr_ptr), .gnt_oh(pick_oh), .gnt_idx(pick_idx), .any(pick_any)
  );
  // host_* fields are latched once per grant and reused unchanged for every retry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      gnt                <= '0;
      gnt_oh             <= '0;
      to_cnt             <= '0;
      gap_cnt            <= '0;
      retry_cnt          <= '0;
      done               <= '0;
      rsp_data           <= '0;
      rsp_status         <= ST_OK;
      arb_idle           <= 1'b0;
      bus.host_send      <= 1'b0;
      bus.host_address   <= '0;
      bus.host_data_in   <= '0;
      bus.host_read_only <= 1'b0;
    end else begin
      done          <= '0;
      bus.host_send <= 1'b0;
      arb_idle      <= 1'b0;
      case (state)
        IDLE:
          if (!bus.host_busy && pick_any) begin
            gnt                <= pick_idx;
            gnt_oh             <= pick_oh;
            bus.host_address   <= req_addr[7*pick_idx +: 7];
            bus.host_data_in   <= req_data[8*pick_idx +: 8];
            bus.host_read_only <= req_rd[pick_idx];
            bus.host_send      <= 1'b1;
            state              <= ISSUE;
          end else arb_idle <= !bus.host_busy;
        ISSUE: begin
          to_cnt <= TO_LOAD;
          state  <= WAIT_BUSY;
        end
        WAIT_BUSY:
          if (bus.host_busy) state <= WAIT_DONE;
          else begin
            to_cnt <= to_cnt - 1'b1;
            if (to_cnt == TW'(1)) begin
              done       <= gnt_oh;
              rsp_status <= ST_TIMEOUT;
              rsp_data   <= '0;
              state      <= COMPLETE;
            end
          end
        WAIT_DONE:
          if (!bus.host_busy) begin
            if (bus.host_ack_error && retry_cnt < MAX_R) begin
              retry_cnt <= retry_cnt + 1'b1;
              gap_cnt   <= GAP_LOAD;
              state     <= GAP;
            end else begin
              done       <= gnt_oh;
              rsp_status <= bus.host_ack_error ? ST_NACK : ST_OK;
              rsp_data   <= (bus.host_ack_error || !bus.host_read_only) ? '0 : bus.host_data_send;
              state      <= COMPLETE;
            end
          end
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == GW'(1)) begin
            bus.host_send <= 1'b1;
            state         <= ISSUE;
          end
        end
        COMPLETE: begin
          rr_ptr     <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
          retry_cnt  <= '0;
          rsp_status <= ST_OK;
          rsp_data   <= '0;
          arb_idle   <= !bus.host_busy;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_host_arbiter.sv
// tb_i2c_host_arbiter: directed + randomized checks against a behavioural host and round-robin model
module tb_i2c_host_arbiter;
  localparam int N = 4, MR = 2, RG = 64, BT = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, req_rd = '0, done;
  logic [7*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_data = '0;
  logic [7:0] rsp_data;
  logic [1:0] rsp_status;
  logic arb_idle;
  i2c_host_arbiter_if bus();
  i2c_host_arbiter #(.NUM_REQ(N), .MAX_RETRY(MR), .RETRY_GAP(RG), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .req_rd(req_rd), .done(done), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .arb_idle(arb_idle), .bus(bus)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0, bad = 0;
  int plan_id = 0, plan_nacks = 0, plan_len = 2, plan_pre = 1;
  bit plan_dead = 1'b0;
  logic [7:0] plan_byte = 8'h00;
  int send_n, fall_cyc;
  int send_cyc[1024];
  logic [6:0] send_addr[1024];
  logic [7:0] send_dat[1024];
  logic send_rd[1024], send_w[1024];
  logic [6:0] r_addr[N];
  logic [7:0] r_data[N];
  logic r_rd[N];
  int m_ptr = 0;
  // host: busy rises plan_pre cycles after send, lasts plan_len; first plan_nacks attempts are NACKed
  initial begin : host_model
    int seen, att;
    seen = -1; att = 0; send_n = 0; fall_cyc = -100;
    bus.host_busy = 1'b0; bus.host_ack_error = 1'b0; bus.host_data_send = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.host_send === 1'b1) begin
        if (seen != plan_id) begin seen = plan_id; att = 0; end
        send_cyc[send_n]  = cyc;
        send_addr[send_n] = bus.host_address;
        send_dat[send_n]  = bus.host_data_in;
        send_rd[send_n]   = bus.host_read_only;
        @(negedge clk);
        send_w[send_n] = bus.host_send;
        send_n++;
        if (!plan_dead) begin
          repeat (plan_pre - 1) @(negedge clk);
          bus.host_busy = 1'b1; bus.host_ack_error = 1'b1; bus.host_data_send = 8'($urandom);
          repeat (plan_len) @(negedge clk);
          bus.host_ack_error = (att < plan_nacks);
          bus.host_data_send = plan_byte;
          bus.host_busy = 1'b0;
          fall_cyc = cyc;
          att++;
        end
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] pend, input int ptr);
    for (int k = 0; k < N; k++) if (pend[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction
  task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] d, input logic rd);
    r_addr[i] = a; r_data[i] = d; r_rd[i] = rd;
    req_addr[7*i +: 7] = a; req_data[8*i +: 8] = d; req_rd[i] = rd;
  endtask
  task automatic set_plan(input int nacks, input bit dead, input logic [7:0] b, input int len, input int pre);
    plan_nacks = nacks; plan_dead = dead; plan_byte = b; plan_len = len; plan_pre = pre;
    plan_id++;
  endtask
  task automatic serve(input int g, input bit hold);
    int base, w, n, d_cyc;
    logic [1:0] es;
    logic [7:0] ed;
    int en;
    es = plan_dead ? 2'b10 : (plan_nacks > MR ? 2'b01 : 2'b00);
    en = plan_dead ? 1 : ((plan_nacks > MR ? MR : plan_nacks) + 1);
    ed = (es == 2'b00 && r_rd[g]) ? plan_byte : 8'h00;
    base = send_n; w = 0;
    do begin @(negedge clk); w++; end while (done === '0 && w < 3000);
    check("done_seen", 32'(w < 3000), 1);
    d_cyc = cyc;
    if (!hold) req[g] = 1'b0;
    check("done_vec", 32'(done), 1 << g);
    check("status", 32'(rsp_status), 32'(es));
    check("rsp_data", 32'(rsp_data), 32'(ed));
    n = send_n - base;
    check("sends", n, en);
    if (n > 0) begin
      check("host_addr", 32'(send_addr[base]), 32'(r_addr[g]));
      check("host_data", 32'(send_dat[base]), 32'(r_data[g]));
      check("host_rd", 32'(send_rd[base]), 32'(r_rd[g]));
      check("send_width", 32'(send_w[base]), 0);
      if (es == 2'b10) check("timeout_lat", d_cyc - send_cyc[base + n - 1], BT + 1);
      else check("done_lat", d_cyc - fall_cyc, 1);
      for (int i = 1; i < n; i++)
        check("retry_gap", 32'(send_cyc[base + i] - send_cyc[base + i - 1] > RG), 1);
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    m_ptr = (g + 1) % N;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
  endtask
  initial begin : main
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done), 0);
    check("rst_status", 32'(rsp_status), 0);
    check("rst_send", 32'(bus.host_send), 0);
    check("rst_addr", 32'(bus.host_address), 0);
    check("rst_idle", 32'(arb_idle), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_rst", 32'(arb_idle), 1);
    set_req(1, 7'h48, 8'hA5, 1'b0);
    set_plan(0, 1'b0, 8'h77, 3, 1);
    req = 4'b0010;
    serve(1, 1'b0);
    set_req(2, 7'h1D, 8'h00, 1'b1);
    set_plan(0, 1'b0, 8'h3C, 4, 2);
    req = 4'b0100;
    serve(2, 1'b0);
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 7'($urandom), 8'($urandom), 1'($urandom));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      set_plan(0, 1'b0, 8'($urandom), $urandom_range(1, 5), $urandom_range(1, 3));
      serve(k % N, 1'b1);
    end
    req = '0;
    set_req(3, 7'h50, 8'h11, 1'b1);
    set_plan(2, 1'b0, 8'hC3, 3, 1);
    req = 4'b1000;
    serve(pick(4'b1000, m_ptr), 1'b0);
    set_req(0, 7'h51, 8'h22, 1'b0);
    set_plan(3, 1'b0, 8'h99, 2, 2);
    req = 4'b0001;
    serve(pick(4'b0001, m_ptr), 1'b0);
    set_req(1, 7'h60, 8'h33, 1'b0);
    set_req(2, 7'h61, 8'h44, 1'b1);
    set_plan(0, 1'b1, 8'h00, 1, 1);
    req = 4'b0110;
    serve(1, 1'b0);
    set_plan(0, 1'b0, 8'h5E, 2, 1);
    serve(2, 1'b0);
    for (int b = 0; b < 8; b++) begin
      logic [N-1:0] pend;
      pend = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) set_req(i, 7'($urandom), 8'($urandom), 1'($urandom));
      req = pend;
      while (pend != '0) begin
        int g;
        g = pick(pend, m_ptr);
        set_plan($urandom_range(0, 3), ($urandom_range(0, 7) == 0), 8'($urandom),
                 $urandom_range(1, 6), $urandom_range(1, 3));
        serve(g, 1'b0);
        pend[g] = 1'b0;
      end
    end
    begin
      int w, sends_busy;
      set_req(2, 7'h21, 8'h00, 1'b1);
      set_plan(0, 1'b0, 8'h00, 40, 1);
      req = 4'b0100;
      w = 0;
      while (bus.host_busy !== 1'b1 && w < 50) begin @(negedge clk); w++; end
      check("busy_seen", 32'(w < 50), 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_done", 32'(done), 0);
      check("midrst_send", 32'(bus.host_send), 0);
      check("midrst_addr", 32'(bus.host_address), 0);
      check("midrst_data", 32'(bus.host_data_in), 0);
      check("midrst_rd", 32'(bus.host_read_only), 0);
      check("midrst_rsp", 32'({rsp_status, rsp_data}), 0);
      check("midrst_idle", 32'(arb_idle), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 0;
      set_plan(0, 1'b0, 8'h5A, 3, 1);
      sends_busy = 0; w = 0;
      while (bus.host_busy === 1'b1 && w < 200) begin
        @(negedge clk);
        w++;
        if (bus.host_send === 1'b1 && bus.host_busy === 1'b1) sends_busy++;
      end
      check("busy_release", 32'(w < 200), 1);
      check("no_send_busy", sends_busy, 0);
      serve(2, 1'b0);
    end
    repeat (3) @(negedge clk);
    check("final_idle", 32'(arb_idle), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
